uart_rx_buffer: RTL and testbench

//  Byte FIFO between uart_rx and the system-bus side.
//  - Captures each byte uart_rx delivers on receive_sig/data.
//  - Holds bytes until a bus agent pops them.
//  - Flags overflow, and flags line-idle once data has been waiting IDLE_CLKS cycles.
//  - Lets a bus master read receive data at its own rate, without losing back-to-back bytes.

---
 rtl/uart_rx_buffer.sv | 98 +++++++++
 tb/tb_uart_rx_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// Byte FIFO between uart_rx and the bus side: edge-detected writes, show-ahead reads,
// sticky overflow and a line-idle flag once data has sat untouched for IDLE_CLKS clocks.
module uart_rx_buffer #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int IDLE_CLKS = 870
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_sig,
    input  logic [7:0]        rx_byte,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic              rx_idle
);

    localparam int                IW       = $clog2(IDLE_CLKS + 1);
    localparam logic [IW-1:0]     IDLE_MAX = IW'(IDLE_CLKS);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];

    logic              rx_sig_q, rx_sig_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [IW-1:0]     idle_cnt_q, idle_cnt_d;

    logic wr, do_wr, do_rd;

    always_comb begin
        rx_sig_d = rx_sig;
        wr       = rx_sig & ~rx_sig_q;
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        do_rd    = rd_en & ~empty;
        // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
        do_wr    = wr & (~full | do_rd);

        wptr_d = do_wr ? wptr_q + ADDR_W'(1) : wptr_q;
        rptr_d = do_rd ? rptr_q + ADDR_W'(1) : rptr_q;

        count_d = count_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (wr & ~do_wr)
            overflow_d = 1'b1;
        else if (clr_overflow)
            overflow_d = 1'b0;

        idle_cnt_d = idle_cnt_q;
        if (wr | empty)
            idle_cnt_d = '0;
        else if (idle_cnt_q != IDLE_MAX)
            idle_cnt_d = idle_cnt_q + IW'(1);

        rd_data  = empty ? 8'h00 : mem[rptr_q];
        count    = count_q;
        overflow = overflow_q;
        rx_idle  = (idle_cnt_q == IDLE_MAX) & ~empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sig_q   <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            rx_sig_q   <= rx_sig_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Storage is deliberately left out of reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wptr_q] <= rx_byte;
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: reset, single byte, held strobe, fill/overflow,
// concurrent read/write, idle flag and mid-operation reset.
module tb_uart_rx_buffer;

    localparam int DEPTH     = 16;
    localparam int ADDR_W    = 4;
    localparam int IDLE_CLKS = 870;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_sig;
    logic [7:0]        rx_byte;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_overflow;
    logic              rx_idle;

    int tests_run    = 0;
    int tests_failed = 0;

    uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IDLE_CLKS(IDLE_CLKS)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_sig       (rx_sig),
        .rx_byte      (rx_byte),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .rx_idle      (rx_idle)
    );

    always #50 clk = ~clk;

    // Stimulus drivers: inputs change and outputs are sampled on the falling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_sig  = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_sig  = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_sig = 1'b0; rx_byte = 8'h00; rd_en = 1'b0; clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0 || rx_idle !== 1'b0 ||
            rd_data !== 8'h00 || full !== 1'b0) begin
            $display("FAIL reset: empty=%b count=%0d ovf=%b idle=%b rd_data=%h full=%b, want 1 0 0 0 00 0",
                     empty, count, overflow, rx_idle, rd_data, full);
            tests_failed++;
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        send_byte(8'h3F);
        @(negedge clk);
        tests_run++;
        if (empty !== 1'b0 || count !== 5'd1 || rd_data !== 8'h3F) begin
            $display("FAIL single_write: empty=%b count=%0d rd_data=%h, want 0 1 3f", empty, count, rd_data);
            tests_failed++;
        end
        pop();
        tests_run++;
        if (empty !== 1'b1 || count !== 5'd0 || rd_data !== 8'h00) begin
            $display("FAIL single_pop: empty=%b count=%0d rd_data=%h, want 1 0 00", empty, count, rd_data);
            tests_failed++;
        end
        // Pop while empty must be ignored.
        pop();
        tests_run++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            $display("FAIL underflow: empty=%b count=%0d, want 1 0", empty, count);
            tests_failed++;
        end
    endtask

    task automatic test_level_held();
        @(negedge clk);
        rx_sig  = 1'b1;
        rx_byte = 8'hAB;
        repeat (87) @(negedge clk);
        rx_sig = 1'b0;
        @(negedge clk);
        tests_run++;
        if (count !== 5'd1 || rd_data !== 8'hAB) begin
            $display("FAIL level_held: count=%0d rd_data=%h, want 1 ab", count, rd_data);
            tests_failed++;
        end
        pop();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
        tests_run++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            $display("FAIL fill: full=%b count=%0d ovf=%b, want 1 16 0", full, count, overflow);
            tests_failed++;
        end
        send_byte(8'hFF);
        tests_run++;
        if (overflow !== 1'b1 || count !== 5'd16 || rd_data !== 8'h00) begin
            $display("FAIL overflow: ovf=%b count=%0d head=%h, want 1 16 00", overflow, count, rd_data);
            tests_failed++;
        end
        for (int i = 0; i < DEPTH; i++) begin
            tests_run++;
            if (rd_data !== 8'(i)) begin
                $display("FAIL drain[%0d]: rd_data=%h, want %h", i, rd_data, 8'(i));
                tests_failed++;
            end
            pop();
        end
        tests_run++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            $display("FAIL drained: empty=%b ovf=%b, want 1 1 (sticky)", empty, overflow);
            tests_failed++;
        end
        @(negedge clk); clr_overflow = 1'b1;
        @(negedge clk); clr_overflow = 1'b0;
        tests_run++;
        if (overflow !== 1'b0) begin
            $display("FAIL clr_overflow: ovf=%b, want 0", overflow);
            tests_failed++;
        end
    endtask

    task automatic test_concurrent();
        // Empty FIFO: write and pop together -> only the write happens, no fall-through.
        @(negedge clk);
        rx_sig = 1'b1; rx_byte = 8'hC3; rd_en = 1'b1;
        @(negedge clk);
        rx_sig = 1'b0; rd_en = 1'b0;
        tests_run++;
        if (count !== 5'd1 || rd_data !== 8'hC3) begin
            $display("FAIL concurrent_empty: count=%0d rd_data=%h, want 1 c3", count, rd_data);
            tests_failed++;
        end
        pop();
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i));
        @(negedge clk);
        rx_sig = 1'b1; rx_byte = 8'h55; rd_en = 1'b1;
        @(negedge clk);
        rx_sig = 1'b0; rd_en = 1'b0;
        tests_run++;
        if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1 || rd_data !== 8'h11) begin
            $display("FAIL concurrent_full: count=%0d ovf=%b full=%b head=%h, want 16 0 1 11",
                     count, overflow, full, rd_data);
            tests_failed++;
        end
        for (int i = 1; i < DEPTH; i++) pop();
        tests_run++;
        if (count !== 5'd1 || rd_data !== 8'h55) begin
            $display("FAIL concurrent_last: count=%0d rd_data=%h, want 1 55", count, rd_data);
            tests_failed++;
        end
        pop();
    endtask

    task automatic test_idle();
        send_byte(8'h77);
        repeat (IDLE_CLKS - 1) @(negedge clk);
        tests_run++;
        if (rx_idle !== 1'b0) begin
            $display("FAIL idle_early: rx_idle=%b, want 0", rx_idle);
            tests_failed++;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (rx_idle !== 1'b1) begin
            $display("FAIL idle_set: rx_idle=%b, want 1", rx_idle);
            tests_failed++;
        end
        send_byte(8'h78);
        tests_run++;
        if (rx_idle !== 1'b0 || count !== 5'd2) begin
            $display("FAIL idle_clr_on_wr: rx_idle=%b count=%0d, want 0 2", rx_idle, count);
            tests_failed++;
        end
        pop();
        pop();
        repeat (IDLE_CLKS + 5) @(negedge clk);
        tests_run++;
        if (rx_idle !== 1'b0 || empty !== 1'b1) begin
            $display("FAIL idle_drained: rx_idle=%b empty=%b, want 0 1", rx_idle, empty);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA1);
        send_byte(8'hA2);
        @(negedge clk);
        rx_sig = 1'b1; rx_byte = 8'h5A;
        reset  = 1'b0;
        @(negedge clk);
        tests_run++;
        if (empty !== 1'b1 || count !== 5'd0 || rd_data !== 8'h00) begin
            $display("FAIL reset_mid: empty=%b count=%0d rd_data=%h, want 1 0 00", empty, count, rd_data);
            tests_failed++;
        end
        // rx_sig already high when reset releases counts as an edge.
        reset = 1'b1;
        @(negedge clk);
        rx_sig = 1'b0;
        tests_run++;
        if (count !== 5'd1 || rd_data !== 8'h5A) begin
            $display("FAIL reset_release_edge: count=%0d rd_data=%h, want 1 5a", count, rd_data);
            tests_failed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_level_held();
        test_fill_overflow();
        test_concurrent();
        test_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
